dependency_check_unit: RTL and testbench
========================================

Name: dependency_check_unit

Overview:
- Decode-stage hazard and forwarding controller for the 8-bit MIPS pipeline.
- Produces the operand-select controls consumed by Register_File: mux_sel_a, mux_sel_b and Imm_sel.
- Tracks the destination registers of the three older in-flight instructions (EX, DM, WB).
- For each newly decoded instruction it picks the youngest producing stage per source operand, or raises a one-cycle load-use stall.

Parameters:
- INS_W, 20, instruction width.
- REG_W, 5, register-address width.
- ZERO_REG, 0, register address that is never forwarded and never stalls (hardwired zero).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- Ins  input  20  instruction currently in decode.
- ins_valid  input  1  Ins holds a real instruction this cycle.
- mux_sel_a  output  2  operand A source select (registered).
- mux_sel_b  output  2  operand B source select (registered).
- Imm_sel  output  1  operand B comes from Imm (registered).
- RW_ex  output  5  destination of the instruction now in EX (registered).
- wr_ex  output  1  instruction in EX writes a register (registered).
- stall  output  1  hold PC and decode this cycle (combinational).

Behaviour:
- Instruction fields: opcode = Ins[19:15], RW = Ins[14:10], RA = Ins[9:5], RB = Ins[4:0].
- Opcode classes:
  - 5'h00: NOP; no write, no reads.
  - 5'h01–5'h0F: reg-reg ALU; writes RW, reads RA and RB.
  - 5'h10–5'h17: ALU-immediate; writes RW, reads RA, Imm_sel = 1.
  - 5'h18: load; writes RW, reads RA, Imm_sel = 1.
  - 5'h19: store; no write, reads RA and RB, Imm_sel = 1.
  - 5'h1A–5'h1F: branch/jump; no write, reads RA and RB.
- History state: three entries, EX/DM/WB, each {dest[4:0], wr, is_load}.
  - On every clock the entries shift EX→DM→WB.
  - The oldest WB entry is discarded.
- Select encoding:
  - 00 = register file.
  - 01 = ans_ex (EX result).
  - 10 = mux_ans_dm (DM result).
  - 11 = ans_wb (WB result).
- Select per source operand: compare against the history entries with wr = 1 and dest != ZERO_REG.
  - Priority is EX > DM > WB; the youngest match wins.
  - No match gives 00.
  - An operand the opcode does not read gives 00.
- Load-use hazard:
  - Condition: ins_valid, the EX entry has is_load = 1, and its dest equals a source the current opcode reads (dest != ZERO_REG).
  - Response: stall = 1 in that same cycle (combinational).
  - At the edge, a bubble {0, 0, 0} enters EX; the registered outputs become mux_sel_a = 00, mux_sel_b = 00, Imm_sel = 0, wr_ex = 0.
  - Ins is not consumed and must be presented again.
  - Next cycle the load sits in DM, so the same operand selects 10 and stall = 0.
- Normal accept (ins_valid = 1, stall = 0):
  - At the edge, the EX entry is loaded from Ins.
  - mux_sel_a, mux_sel_b, Imm_sel, RW_ex and wr_ex update from the same decode.
  - Latency is one clock: the controls are valid during the instruction's EX cycle.
- ins_valid = 0: a bubble enters EX, all selects go to 00, and stall = 0.
- Simultaneous matches: if RA == RB and both match, both selects carry the same code.
- Self-reference (RW == RA within one instruction): compared only against older entries, never against itself.
- Reset (rst = 1 at the edge):
  - All history entries become {0, 0, 0}.
  - mux_sel_a = 00, mux_sel_b = 00, Imm_sel = 0, RW_ex = 0, wr_ex = 0.
  - stall is forced to 0 while rst = 1.
  - Reset mid-stall drops the pending hazard; the first instruction after reset sees empty history.

Test Plan:
1. Reset, then Ins = 20'h00043 (NOP opcode) with ins_valid = 1 → after one edge: selects 00/00, Imm_sel = 0, wr_ex = 0, stall = 0.
2. Back-to-back ALU: issue opcode 01, RW = 2; then opcode 02, RA = 2, RB = 3 → second instruction in EX has mux_sel_a = 01, mux_sel_b = 00.
3. Distance 2 and 3: producer RW = 5, one NOP, consumer RB = 5 → mux_sel_b = 10. With two NOPs → mux_sel_b = 11. With three NOPs → 00.
4. Load-use:
   - Issue load (5'h18) with RW = 4, then ALU reading RA = 4 → stall = 1 for exactly one cycle and a bubble in EX (selects 00, wr_ex = 0).
   - The re-presented ALU then gets mux_sel_a = 10.
   - Immediate opcode 5'h10 produces Imm_sel = 1.
5. Priority and zero register:
   - Writers to r7 in EX and in DM → a consumer reading r7 gets 01.
   - A producer writing r0 followed by a consumer reading r0 → 00 and no stall.
6. Reset mid-hazard: assert rst in the cycle where stall = 1 → the next cycle has stall = 0, all outputs 00/0, and the history is cleared.

Source files
------------

// File: rtl/dependency_check_unit.sv
// dependency_check_unit: decode-stage forwarding select and load-use stall generator
// tracking the destinations of the EX, DM and WB instructions.
module dependency_check_unit #(
   parameter int INS_W = 20,
   parameter int REG_W = 5,
   parameter logic [REG_W-1:0] ZERO_REG = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [INS_W-1:0] Ins,
   input  logic             ins_valid,
   output logic [1:0]       mux_sel_a,
   output logic [1:0]       mux_sel_b,
   output logic             Imm_sel,
   output logic [REG_W-1:0] RW_ex,
   output logic             wr_ex,
   output logic             stall
);
   logic [4:0]       op;
   logic [REG_W-1:0] rw, ra, rb;
   logic             writes, rd_a, rd_b, imm, ld, accept;
   logic [REG_W-1:0] ex_dest_q, ex_dest_d, dm_dest_q, dm_dest_d, wb_dest_q, wb_dest_d;
   logic             ex_wr_q, ex_wr_d, dm_wr_q, dm_wr_d, wb_wr_q, wb_wr_d;
   logic             ex_ld_q, ex_ld_d, dm_ld_q, dm_ld_d, wb_ld_q, wb_ld_d;
   logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d, fwd_a, fwd_b;
   logic             imm_q, imm_d;

   function automatic logic hit(input logic wr, input logic [REG_W-1:0] dest, input logic [REG_W-1:0] r);
      return wr && dest != ZERO_REG && dest == r;
   endfunction

   assign op = Ins[INS_W-1 -: 5];
   assign rw = Ins[3*REG_W-1 -: REG_W];
   assign ra = Ins[2*REG_W-1 -: REG_W];
   assign rb = Ins[REG_W-1:0];

   always_comb begin
      writes = op != 5'h00 && op <= 5'h18;
      rd_a   = op != 5'h00;
      rd_b   = (op != 5'h00 && op <= 5'h0F) || op >= 5'h19;
      imm    = op >= 5'h10 && op <= 5'h19;
      ld     = op == 5'h18;
      // only a load still in EX cannot forward; its data appears one stage later
      stall  = !rst && ins_valid && ex_ld_q && ex_dest_q != ZERO_REG &&
               ((rd_a && ra == ex_dest_q) || (rd_b && rb == ex_dest_q));
      accept = ins_valid && !stall;
      fwd_a  = !rd_a ? 2'b00 : hit(ex_wr_q, ex_dest_q, ra) ? 2'b01 :
               hit(dm_wr_q, dm_dest_q, ra) ? 2'b10 : hit(wb_wr_q, wb_dest_q, ra) ? 2'b11 : 2'b00;
      fwd_b  = !rd_b ? 2'b00 : hit(ex_wr_q, ex_dest_q, rb) ? 2'b01 :
               hit(dm_wr_q, dm_dest_q, rb) ? 2'b10 : hit(wb_wr_q, wb_dest_q, rb) ? 2'b11 : 2'b00;
      ex_dest_d = accept ? rw : '0;
      ex_wr_d   = accept && writes;
      ex_ld_d   = accept && ld;
      dm_dest_d = ex_dest_q;
      dm_wr_d   = ex_wr_q;
      dm_ld_d   = ex_ld_q;
      wb_dest_d = dm_dest_q;
      wb_wr_d   = dm_wr_q;
      wb_ld_d   = dm_ld_q;
      sel_a_d   = accept ? fwd_a : 2'b00;
      sel_b_d   = accept ? fwd_b : 2'b00;
      imm_d     = accept && imm;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_dest_q <= '0;
         ex_wr_q   <= 1'b0;
         ex_ld_q   <= 1'b0;
         dm_dest_q <= '0;
         dm_wr_q   <= 1'b0;
         dm_ld_q   <= 1'b0;
         wb_dest_q <= '0;
         wb_wr_q   <= 1'b0;
         wb_ld_q   <= 1'b0;
         sel_a_q   <= 2'b00;
         sel_b_q   <= 2'b00;
         imm_q     <= 1'b0;
      end else begin
         ex_dest_q <= ex_dest_d;
         ex_wr_q   <= ex_wr_d;
         ex_ld_q   <= ex_ld_d;
         dm_dest_q <= dm_dest_d;
         dm_wr_q   <= dm_wr_d;
         dm_ld_q   <= dm_ld_d;
         wb_dest_q <= wb_dest_d;
         wb_wr_q   <= wb_wr_d;
         wb_ld_q   <= wb_ld_d;
         sel_a_q   <= sel_a_d;
         sel_b_q   <= sel_b_d;
         imm_q     <= imm_d;
      end
   end

   assign mux_sel_a = sel_a_q;
   assign mux_sel_b = sel_b_q;
   assign Imm_sel   = imm_q;
   assign RW_ex     = ex_dest_q;
   assign wr_ex     = ex_wr_q;
endmodule

// File: tb/tb_dependency_check_unit.sv
// tb_dependency_check_unit: directed vector table, reset-mid-stall sequence and
// randomized run against a history-list reference model.
module tb_dependency_check_unit;
   logic        clk = 1'b0;
   logic        rst, ins_valid;
   logic [19:0] Ins;
   logic [1:0]  mux_sel_a, mux_sel_b;
   logic        Imm_sel, wr_ex, stall;
   logic [4:0]  RW_ex;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          r;
      logic [19:0] ins;
      bit          v;
      bit          st;
      logic [1:0]  a, b;
      bit          imm, wr;
      logic [4:0]  rw;
   } vec_t;

   typedef struct {
      logic [4:0] dest;
      bit         wr;
      bit         ld;
   } ent_t;

   vec_t vecs[$];
   ent_t hist[3];

   dependency_check_unit dut (
      .clk(clk), .rst(rst), .Ins(Ins), .ins_valid(ins_valid),
      .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b), .Imm_sel(Imm_sel),
      .RW_ex(RW_ex), .wr_ex(wr_ex), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] mk(input logic [4:0] op, input logic [4:0] rw, input logic [4:0] ra, input logic [4:0] rb);
      return {op, rw, ra, rb};
   endfunction

   function automatic void add(input bit r, input logic [19:0] ins, input bit v, input bit st,
                               input logic [1:0] a, input logic [1:0] b, input bit imm, input bit wr, input logic [4:0] rw);
      vec_t t;
      t.r = r; t.ins = ins; t.v = v; t.st = st; t.a = a; t.b = b; t.imm = imm; t.wr = wr; t.rw = rw;
      vecs.push_back(t);
   endfunction

   // Reference decode straight from the opcode class table
   function automatic bit m_writes(input logic [4:0] op); return op >= 5'h01 && op <= 5'h18; endfunction
   function automatic bit m_reads_a(input logic [4:0] op); return op != 5'h00; endfunction
   function automatic bit m_reads_b(input logic [4:0] op);
      return (op >= 5'h01 && op <= 5'h0F) || op == 5'h19 || op >= 5'h1A;
   endfunction
   function automatic bit m_imm(input logic [4:0] op); return op >= 5'h10 && op <= 5'h19; endfunction

   // Distance to the youngest live producer (1=EX, 2=DM, 3=WB), 0 if none
   function automatic logic [1:0] m_sel(input bit rd, input logic [4:0] r);
      if (!rd) return 2'd0;
      for (int k = 0; k < 3; k++)
         if (hist[k].wr && hist[k].dest != 5'd0 && hist[k].dest == r) return 2'(k + 1);
      return 2'd0;
   endfunction

   function automatic bit m_stall(input bit r, input logic [19:0] ins, input bit v);
      logic [4:0] op = ins[19:15];
      if (r || !v || !hist[0].ld || hist[0].dest == 5'd0) return 1'b0;
      return (m_reads_a(op) && ins[9:5] == hist[0].dest) || (m_reads_b(op) && ins[4:0] == hist[0].dest);
   endfunction

   task automatic drive(input bit r, input logic [19:0] ins, input bit v);
      @(negedge clk);
      rst = r; Ins = ins; ins_valid = v;
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [1:0] a, input logic [1:0] b, input bit imm, input bit wr, input logic [4:0] rw);
      chk({tag, " mux_sel_a"}, 32'(mux_sel_a), 32'(a));
      chk({tag, " mux_sel_b"}, 32'(mux_sel_b), 32'(b));
      chk({tag, " Imm_sel"}, 32'(Imm_sel), 32'(imm));
      chk({tag, " wr_ex"}, 32'(wr_ex), 32'(wr));
      if (wr) chk({tag, " RW_ex"}, 32'(RW_ex), 32'(rw));
   endtask

   initial begin
      rst = 1'b1; Ins = '0; ins_valid = 1'b0;
      // reset / NOP
      add(1, 20'h0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 20'h00043, 1, 0, 0, 0, 0, 0, 0);
      // back-to-back ALU
      add(0, mk(5'h01, 2, 0, 0), 1, 0, 0, 0, 0, 1, 2);
      add(0, mk(5'h02, 9, 2, 3), 1, 0, 2'b01, 0, 0, 1, 9);
      // distance 2
      add(0, mk(5'h01, 5, 0, 0), 1, 0, 0, 0, 0, 1, 5);
      add(0, 20'h0, 1, 0, 0, 0, 0, 0, 0);
      add(0, mk(5'h03, 6, 0, 5), 1, 0, 0, 2'b10, 0, 1, 6);
      // distance 3 (second gap is an invalid slot carrying a writer encoding)
      add(0, mk(5'h01, 10, 0, 0), 1, 0, 0, 0, 0, 1, 10);
      add(0, mk(5'h01, 10, 10, 10), 0, 0, 0, 0, 0, 0, 0);
      add(0, 20'h0, 1, 0, 0, 0, 0, 0, 0);
      add(0, mk(5'h04, 11, 0, 10), 1, 0, 0, 2'b11, 0, 1, 11);
      // distance 4: out of window
      add(0, mk(5'h01, 12, 0, 0), 1, 0, 0, 0, 0, 1, 12);
      add(0, 20'h0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 20'h0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 20'h0, 1, 0, 0, 0, 0, 0, 0);
      add(0, mk(5'h05, 13, 0, 12), 1, 0, 0, 0, 0, 1, 13);
      // load-use: stall + bubble, then DM forward, then immediate
      add(0, mk(5'h18, 4, 0, 0), 1, 0, 0, 0, 1, 1, 4);
      add(0, mk(5'h01, 14, 4, 0), 1, 1, 0, 0, 0, 0, 0);
      add(0, mk(5'h01, 14, 4, 0), 1, 0, 2'b10, 0, 0, 1, 14);
      add(0, mk(5'h10, 15, 14, 7), 1, 0, 2'b01, 0, 1, 1, 15);
      // EX beats DM, RA==RB
      add(0, mk(5'h01, 7, 0, 0), 1, 0, 0, 0, 0, 1, 7);
      add(0, mk(5'h01, 7, 0, 0), 1, 0, 0, 0, 0, 1, 7);
      add(0, mk(5'h02, 16, 7, 7), 1, 0, 2'b01, 2'b01, 0, 1, 16);
      // load into r0: never stalls, never forwards
      add(0, mk(5'h18, 0, 0, 0), 1, 0, 0, 0, 1, 1, 0);
      add(0, mk(5'h01, 17, 0, 0), 1, 0, 0, 0, 0, 1, 17);
      add(0, mk(5'h18, 8, 0, 0), 1, 0, 0, 0, 1, 1, 8);

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].ins, vecs[i].v);
         chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].st));
         @(posedge clk); #1;
         check_outs($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].wr, vecs[i].rw);
      end

      // reset asserted in the stall cycle
      drive(0, mk(5'h01, 18, 8, 0), 1);
      chk("midrst pre stall", 32'(stall), 32'd1);
      rst = 1'b1; #1;
      chk("midrst forced stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      check_outs("midrst", 0, 0, 0, 0, 0);
      chk("midrst RW_ex", 32'(RW_ex), 32'd0);
      drive(0, mk(5'h02, 19, 8, 17), 1);
      chk("postrst stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      check_outs("postrst", 0, 0, 0, 1, 19);

      // randomized run against the model
      begin
         logic [19:0] ins;
         bit v, r, hold, es;
         logic [1:0] ea, eb;
         bit eimm, ewr;
         logic [4:0] erw, op;
         ent_t ne;
         drive(1, 20'h0, 0);
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) hist[k] = '{5'd0, 1'b0, 1'b0};
         hold = 0; ins = '0; v = 0;
         for (int n = 0; n < 1500; n++) begin
            if (!hold) begin
               ins = mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)));
               v = $urandom_range(0, 9) != 0;
            end
            r = $urandom_range(0, 59) == 0;
            drive(r, ins, v);
            es = m_stall(r, ins, v);
            chk($sformatf("rnd%0d stall", n), 32'(stall), 32'(es));
            op = ins[19:15];
            ne = '{5'd0, 1'b0, 1'b0};
            ea = 0; eb = 0; eimm = 0; ewr = 0; erw = 0;
            if (!r && v && !es) begin
               ea = m_sel(m_reads_a(op), ins[9:5]);
               eb = m_sel(m_reads_b(op), ins[4:0]);
               eimm = m_imm(op);
               ewr = m_writes(op);
               erw = ins[14:10];
               ne = '{ins[14:10], ewr, op == 5'h18};
            end
            if (r) for (int k = 0; k < 3; k++) hist[k] = '{5'd0, 1'b0, 1'b0};
            else begin
               hist[2] = hist[1];
               hist[1] = hist[0];
               hist[0] = ne;
            end
            @(posedge clk); #1;
            check_outs($sformatf("rnd%0d", n), ea, eb, eimm, ewr, erw);
            hold = es;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
